// File: rtl/xor_eq_pipe_pwr.sv
// Purpose : WIDTH-lane pipelined y = (a ^ b) & ~(~a & ~(c ^ d)) with a saturating
//           out_y toggle counter used as a switching-activity probe.
// Latency : STAGES cycles from input transfer to out_valid; 1 result/cycle sustained.
// Backpr. : in_ready is combinational from out_ready through the stage chain (no skid
//           buffer); a stalled stage holds its contents, so out_y is stable under stall.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready/in_a..in_d operand side;
//           out_valid/out_ready/out_y result side; clr_cnt clears toggle_cnt.
module xor_eq_pipe_pwr #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] toggle_cnt
);

    // Popcount width, and a sum width wide enough that base + pop cannot wrap
    // even when WIDTH exceeds the counter range.
    localparam int PW = $clog2(WIDTH + 1);
    localparam int SW = (PW + 1 > CNT_W + 1) ? PW + 1 : CNT_W + 1;

    logic [WIDTH-1:0]  f_y;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  d [STAGES];

    assign f_y = (in_a ^ in_b) & ~(~in_a & ~(in_c ^ in_d));

    // Advance chain runs backwards from the sink: a stage may load when the
    // stage after it is empty or is itself moving on this cycle.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = out_ready | ~v[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = ~v[k+1] | adv[k+1];
        end
    end

    assign in_ready = ~v[0] | adv[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                v[0] <= in_valid;
                d[0] <= f_y;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    v[k] <= v[k-1];
                    d[k] <= d[k-1];
                end
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign out_y     = d[STAGES-1];

    // Toggle probe: counts bit flips between consecutive accepted results.
    logic             xfer;
    logic [WIDTH-1:0] last;
    logic [PW-1:0]    pop;
    logic [CNT_W-1:0] base;
    logic [SW-1:0]    sum;
    logic             sat;

    assign xfer = out_valid & out_ready;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(out_y[i] ^ last[i]);
        end
    end

    // A clear coinciding with a transfer restarts the count from this pop.
    assign base = clr_cnt ? '0 : toggle_cnt;
    assign sum  = SW'(base) + SW'(pop);
    assign sat  = |sum[SW-1:CNT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_cnt <= '0;
            last       <= '0;
        end else if (xfer) begin
            toggle_cnt <= sat ? '1 : sum[CNT_W-1:0];
            last       <= out_y;
        end else if (clr_cnt) begin
            toggle_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_xor_eq_pipe_pwr.sv
module tb_xor_eq_pipe_pwr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: WIDTH=8, STAGES=2, CNT_W=16
    logic       rst, in_valid, in_ready, out_valid, out_ready, clr_cnt;
    logic [7:0] in_a, in_b, in_c, in_d, out_y;
    logic [15:0] toggle_cnt;

    // DUT B: WIDTH=8, STAGES=2, CNT_W=4 (saturation / clear checks)
    logic       b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr_cnt;
    logic [7:0] b_in_a, b_in_b, b_in_c, b_in_d, b_out_y;
    logic [3:0] b_toggle_cnt;

    xor_eq_pipe_pwr #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .clr_cnt(clr_cnt), .toggle_cnt(toggle_cnt)
    );

    xor_eq_pipe_pwr #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_c(b_in_c), .in_d(b_in_d),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y),
        .clr_cnt(b_clr_cnt), .toggle_cnt(b_toggle_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_f(input logic [7:0] a, b, c, d);
        return (a ^ b) & ~(~a & ~(c ^ d));
    endfunction

    task automatic drive_a(input logic [7:0] a, b, c, d);
        in_a = a; in_b = b; in_c = c; in_d = d;
    endtask

    task automatic drive_b(input logic [7:0] a, b, c, d);
        b_in_a = a; b_in_b = b; b_in_c = c; b_in_d = d;
    endtask

    logic [7:0] ra [6], rb [6], rc [6], rd [6];
    logic [7:0] expq [$];
    logic       pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int sent, got, infl, cnt_m;
        logic [7:0] last_m, held_y, e;
        logic held_v, ix, ox;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        drive_a(8'h00, 8'h00, 8'h00, 8'h00);
        b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0; b_clr_cnt = 1'b0;
        drive_b(8'h00, 8'h00, 8'h00, 8'h00);
        tick(); tick();

        // ---- reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 8'h00);
        chk("rst_toggle", toggle_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // ---- directed back-to-back trio, latency 2
        out_ready = 1'b1; in_valid = 1'b1;
        drive_a(8'hF0, 8'h0F, 8'h00, 8'h00);           // y = F0
        tick();
        chk("lat_cyc1_valid", out_valid, 0);
        drive_a(8'h00, 8'hFF, 8'hAA, 8'h55);           // y = FF
        tick();
        chk("lat_cyc2_valid", out_valid, 1);
        chk("dir1_y", out_y, 8'hF0);
        chk("dir1_toggle_pre", toggle_cnt, 0);
        drive_a(8'h00, 8'h00, 8'h00, 8'h00);           // y = 00
        tick();
        in_valid = 1'b0;
        chk("dir1_toggle", toggle_cnt, 4);
        chk("dir2_valid", out_valid, 1);
        chk("dir2_y", out_y, 8'hFF);
        tick();
        chk("dir2_toggle", toggle_cnt, 8);
        chk("dir3_y", out_y, 8'h00);
        tick();
        chk("dir3_toggle", toggle_cnt, 16);
        chk("drained_valid", out_valid, 0);

        // ---- random stream under out_ready pattern 1,0,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            ra[i] = 8'($urandom); rb[i] = 8'($urandom);
            rc[i] = 8'($urandom); rd[i] = 8'($urandom);
        end
        sent = 0; got = 0; infl = 0; cnt_m = 16; last_m = 8'h00;
        held_v = 1'b0; held_y = 8'h00;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            if (held_v) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_y_stable", out_y, held_y);
            end
            out_ready = pat[cyc % 6];
            in_valid  = (sent < 6);
            if (sent < 6) drive_a(ra[sent], rb[sent], rc[sent], rd[sent]);
            #1;
            chk("stream_in_ready", in_ready, !(infl == 2 && !out_ready));
            ix = in_valid && in_ready;
            ox = out_valid && out_ready;
            if (ox) begin
                if (expq.size() == 0) begin
                    chk("stream_spurious", out_valid, 0);
                end else begin
                    e = expq.pop_front();
                    chk("stream_order_y", out_y, e);
                    cnt_m  = cnt_m + $countones(e ^ last_m);
                    last_m = e;
                end
                got++;
            end
            held_v = out_valid && !out_ready;
            held_y = out_y;
            if (ix) begin
                expq.push_back(ref_f(ra[sent], rb[sent], rc[sent], rd[sent]));
                sent++;
            end
            infl = infl + int'(ix) - int'(ox);
            tick();
        end
        in_valid = 1'b0;
        chk("stream_count", got, 6);
        chk("stream_toggle", toggle_cnt, cnt_m);

        // ---- reset with two results in flight
        out_ready = 1'b0; in_valid = 1'b1;
        drive_a(8'hF0, 8'h0F, 8'h00, 8'h00);
        tick();
        drive_a(8'hFF, 8'h00, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0;
        chk("flight_full_valid", out_valid, 1);
        chk("flight_full_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_y", out_y, 8'h00);
        chk("midrst_toggle", toggle_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_stale", out_valid, 0);
        end
        in_valid = 1'b1;
        drive_a(8'h00, 8'hFF, 8'hAA, 8'h55);           // y = FF
        tick();
        in_valid = 1'b0;
        chk("postrst_cyc1_valid", out_valid, 0);
        tick();
        chk("postrst_cyc2_valid", out_valid, 1);
        chk("postrst_y", out_y, 8'hFF);

        // ---- DUT B: CNT_W=4 saturation and clear
        b_rst = 1'b0; b_out_ready = 1'b1; b_in_valid = 1'b1;
        drive_b(8'hFF, 8'h00, 8'h00, 8'h00);           // y = FF
        tick();
        drive_b(8'h00, 8'h00, 8'h00, 8'h00);           // y = 00
        tick();
        drive_b(8'hFF, 8'h00, 8'h00, 8'h00);           // y = FF
        tick();
        b_in_valid = 1'b0;
        chk("sat_first", b_toggle_cnt, 8);
        tick();
        chk("sat_clip", b_toggle_cnt, 15);
        tick();
        chk("sat_hold", b_toggle_cnt, 15);
        chk("sat_drained", b_out_valid, 0);
        b_clr_cnt = 1'b1;
        tick();
        b_clr_cnt = 1'b0;
        chk("clr_no_xfer", b_toggle_cnt, 0);

        // last is still FF: 00 gives pop 8, then F0 with clr gives pop 4
        b_in_valid = 1'b1;
        drive_b(8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        drive_b(8'hF0, 8'h0F, 8'h00, 8'h00);
        tick();
        b_in_valid = 1'b0;
        tick();
        chk("clr_pre_cnt", b_toggle_cnt, 8);
        chk("clr_pre_y", b_out_y, 8'hF0);
        b_clr_cnt = 1'b1;
        tick();
        b_clr_cnt = 1'b0;
        chk("clr_with_xfer", b_toggle_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xor_eq_pipe_pwr.md
Name: xor_eq_pipe_pwr

Overview:
Parametrised, pipelined successor of the 4-input XOR/XNOR power sub-circuit. Evaluates, bit-wise over WIDTH lanes, y = (a ^ b) & ~(~a & ~(c ^ d)).
Sits between a stimulus source and a sink with valid/ready handshakes on both sides. Adds a saturating output toggle counter that serves as the switching-activity probe for power experiments.

Parameters:
WIDTH, 8, lane count (bits per operand and result); >= 1
STAGES, 2, pipeline register stages from input to out_y; >= 1
CNT_W, 16, width of toggle_cnt; >= 4

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand set present
in_ready  output  1  block accepts operands this cycle
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_c  input  WIDTH  operand c
in_d  input  WIDTH  operand d
out_valid  output  1  out_y holds a result
out_ready  input  1  sink accepts result
out_y  output  WIDTH  result
clr_cnt  input  1  synchronous clear of toggle_cnt
toggle_cnt  output  CNT_W  saturating count of out_y bit toggles across accepted results

Behaviour:
- Reset (rst=1 at a clock edge): all stage valid bits cleared; out_valid=0, out_y=0, toggle_cnt=0, last-accepted-result register=0. rst overrides every other input. Reset mid-operation drops all in-flight results; none is emitted afterwards.
- Function is combinational on the input operands. The result enters stage 0 and is then carried unchanged through stages 1..STAGES-1. out_y/out_valid are the last stage's data/valid.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Stage k holds (vk, dk). Stage k advances when its downstream accepts:
  - last stage: out_ready | ~v_last
  - other stages: next stage empty or next stage advancing
  - in_ready = stage 0 empty or stage 0 advancing. in_ready is combinational from out_ready through the chain (no skid buffer).
- On advance, stage k loads (v(k-1), d(k-1)); stage 0 loads (in_valid, f(in)). A non-advancing stage holds its contents.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready is held 1. Throughput is 1 result/cycle with no bubbles.
- Order preserved; no drop and no duplication under any out_ready pattern.
- out_y is stable while out_valid=1 and out_ready=0.
- Toggle counter, on each output transfer:
  - pop = popcount(out_y ^ last); then last <= out_y.
  - toggle_cnt <= min(toggle_cnt + pop, 2^CNT_W - 1). The sum is computed at CNT_W+1 bits, then saturated.
  - Once saturated, toggle_cnt holds until clr_cnt or rst.
- clr_cnt=1 without a transfer: toggle_cnt <= 0, last unchanged.
- clr_cnt=1 with a simultaneous transfer: toggle_cnt <= pop (saturated), last <= out_y.
- Stalled cycles and non-transfer cycles never change toggle_cnt or last.

Test Plan:
- Reset, then WIDTH=8, STAGES=2. Send a=F0,b=0F,c=00,d=00 with out_ready=1 -> out_valid rises exactly 2 cycles later, out_y=F0, toggle_cnt=4.
- Next, a=00,b=FF,c=AA,d=55 back-to-back -> out_y=FF on the following cycle, toggle_cnt=8. Then a=b=c=d=00 -> out_y=00, toggle_cnt=16.
- Stream 6 random operand sets with out_ready toggling 1,0,0,1,0,1,...:
  - all 6 results emerge in order and match the reference function;
  - out_y is stable during stalls;
  - in_ready drops only when both stages are full and out_ready=0.
- CNT_W=4, alternate out_y between 00 and FF (pop=8 each) -> toggle_cnt 8 then 15, and stays at 15. Then clr_cnt=1 with no transfer -> 0.
- clr_cnt=1 in the same cycle as a transfer with pop=4 -> toggle_cnt=4, not 0 and not old+4.
- Two results in flight, assert rst for 1 cycle -> out_valid=0, toggle_cnt=0, no stale result appears on later cycles; the next input emerges after 2 cycles.
